memory_board_ctrl: RTL and testbench



---
 rtl/memory_board_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_memory_board_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_board_ctrl.sv
// Controller for a 4x4 memory game: cursor stepping, card reveal, pair matching, turn counter.
// Optional build macro MOVE_SKIP_MATCHED_EN: moves skip matched cells and the cursor freezes in DONE.
module memory_board_ctrl #(
   parameter logic [63:0] DECK        = 64'h1234_5678_8765_4321,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       move,
   input  logic       select,
   output logic [3:0] c1,
   output logic [3:0] c2,
   output logic [3:0] c3,
   output logic [3:0] c4,
   output logic [3:0] c5,
   output logic [3:0] c6,
   output logic [3:0] c7,
   output logic [3:0] c8,
   output logic [3:0] c9,
   output logic [3:0] c10,
   output logic [3:0] c11,
   output logic [3:0] c12,
   output logic [3:0] c13,
   output logic [3:0] c14,
   output logic [3:0] c15,
   output logic [3:0] c16,
   output logic [7:0] counter
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ONE_UP = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cursor_q, cursor_d;
   logic [3:0]  first_q, first_d;
   logic [3:0]  second_q, second_d;
   logic [3:0]  pairs_q, pairs_d;
   logic [15:0] revealed_q, revealed_d;
   logic [15:0] matched_q, matched_d;
   logic [7:0]  timer_q, timer_d;
   logic [7:0]  counter_q, counter_d;
   logic        prev_move_q, prev_move_d;
   logic        prev_select_q, prev_select_d;

   logic        move_ev, select_ev;
   logic [15:0] shown;
   logic [3:0]  next_cursor;
   logic [3:0]  code [16];

   function automatic logic [3:0] face_of(input logic [3:0] idx);
      logic [63:0] sh;
      sh = DECK >> {idx, 2'b00};
      return sh[3:0];
   endfunction

   assign move_ev   = move & ~prev_move_q;
   assign select_ev = select & ~prev_select_q;
   assign shown     = revealed_q | matched_q;

`ifdef MOVE_SKIP_MATCHED_EN
   logic       found;
   logic [3:0] cand;
   // Nearest unmatched cell ahead of the cursor; stays put when none exists.
   always_comb begin
      next_cursor = cursor_q;
      found       = 1'b0;
      cand        = cursor_q;
      if (state_q != S_DONE) begin
         for (int unsigned k = 1; k < 16; k++) begin
            cand = cursor_q + 4'(k);
            if (!found && !matched_q[cand]) begin
               next_cursor = cand;
               found       = 1'b1;
            end
         end
      end
   end
`else
   always_comb begin
      next_cursor = cursor_q + 4'd1;
   end
`endif

   always_comb begin
      state_d       = state_q;
      cursor_d      = cursor_q;
      first_d       = first_q;
      second_d      = second_q;
      pairs_d       = pairs_q;
      revealed_d    = revealed_q;
      matched_d     = matched_q;
      timer_d       = timer_q;
      counter_d     = counter_q;
      prev_move_d   = move;
      prev_select_d = select;

      // Select acts on the pre-move cursor even when both events share an edge.
      if (move_ev) cursor_d = next_cursor;

      case (state_q)
         S_IDLE: begin
            if (select_ev && !shown[cursor_q]) begin
               revealed_d[cursor_q] = 1'b1;
               first_d              = cursor_q;
               state_d              = S_ONE_UP;
            end
         end
         S_ONE_UP: begin
            if (select_ev && !shown[cursor_q]) begin
               revealed_d[cursor_q] = 1'b1;
               second_d             = cursor_q;
               if (counter_q != 8'hFF) counter_d = counter_q + 8'd1;
               if (face_of(cursor_q) == face_of(first_q)) begin
                  matched_d[cursor_q]  = 1'b1;
                  matched_d[first_q]   = 1'b1;
                  revealed_d[cursor_q] = 1'b0;
                  revealed_d[first_q]  = 1'b0;
                  pairs_d              = pairs_q + 4'd1;
                  state_d              = (pairs_q == 4'd7) ? S_DONE : S_IDLE;
               end else begin
                  timer_d = 8'(HOLD_CYCLES);
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (timer_q == 8'd1) begin
               revealed_d[first_q]  = 1'b0;
               revealed_d[second_q] = 1'b0;
               state_d              = S_IDLE;
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cursor_q      <= '0;
         first_q       <= '0;
         second_q      <= '0;
         pairs_q       <= '0;
         revealed_q    <= '0;
         matched_q     <= '0;
         timer_q       <= '0;
         counter_q     <= '0;
         prev_move_q   <= 1'b0;
         prev_select_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cursor_q      <= cursor_d;
         first_q       <= first_d;
         second_q      <= second_d;
         pairs_q       <= pairs_d;
         revealed_q    <= revealed_d;
         matched_q     <= matched_d;
         timer_q       <= timer_d;
         counter_q     <= counter_d;
         prev_move_q   <= prev_move_d;
         prev_select_q <= prev_select_d;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 16; i++) begin
         if (shown[i] || state_q == S_DONE) code[i] = face_of(4'(i));
         else if (cursor_q == 4'(i))        code[i] = 4'hF;
         else                               code[i] = 4'h0;
      end
   end

   assign c1      = code[0];
   assign c2      = code[1];
   assign c3      = code[2];
   assign c4      = code[3];
   assign c5      = code[4];
   assign c6      = code[5];
   assign c7      = code[6];
   assign c8      = code[7];
   assign c9      = code[8];
   assign c10     = code[9];
   assign c11     = code[10];
   assign c12     = code[11];
   assign c13     = code[12];
   assign c14     = code[13];
   assign c15     = code[14];
   assign c16     = code[15];
   assign counter = counter_q;

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Bench for memory_board_ctrl: game-level reference model checked every cycle, plus literal anchors.
module tb_memory_board_ctrl;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst, move, select;
   logic [3:0] c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, c15, c16;
   logic [7:0] counter;
   logic [3:0] dut_c [16];

   int tests = 0;
   int fails = 0;
   int fail_prints = 0;
   int cycle = 0;

   logic [63:0] deck = 64'h1234_5678_8765_4321;
   int  face [16];

   int  m_cur, m_first, m_hold, m_ha, m_hb, m_cnt;
   bit  m_rev [16];
   bit  m_mat [16];
   bit  m_pm, m_ps;

   always #5 clk = ~clk;

   memory_board_ctrl #(
      .DECK        (64'h1234_5678_8765_4321),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk(clk), .rst(rst), .move(move), .select(select),
      .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8),
      .c9(c9), .c10(c10), .c11(c11), .c12(c12), .c13(c13), .c14(c14), .c15(c15), .c16(c16),
      .counter(counter)
   );

   always_comb begin
      dut_c[0]  = c1;  dut_c[1]  = c2;  dut_c[2]  = c3;  dut_c[3]  = c4;
      dut_c[4]  = c5;  dut_c[5]  = c6;  dut_c[6]  = c7;  dut_c[7]  = c8;
      dut_c[8]  = c9;  dut_c[9]  = c10; dut_c[10] = c11; dut_c[11] = c12;
      dut_c[12] = c13; dut_c[13] = c14; dut_c[14] = c15; dut_c[15] = c16;
   end

   function automatic int n_matched();
      int n = 0;
      for (int i = 0; i < 16; i++) if (m_mat[i]) n++;
      return n;
   endfunction

   function automatic int expect_code(int i);
      if (n_matched() == 16 || m_rev[i] || m_mat[i]) return face[i];
      if (i == m_cur) return 15;
      return 0;
   endfunction

   // Game rules applied once per clock edge to the inputs seen at that edge.
   task automatic model_step();
      bit mev, sev;
      int cur0, ncur, nm;
      if (rst) begin
         m_cur = 0; m_first = -1; m_hold = 0; m_cnt = 0; m_pm = 0; m_ps = 0;
         for (int i = 0; i < 16; i++) begin m_rev[i] = 0; m_mat[i] = 0; end
         return;
      end
      mev = move && !m_pm;
      sev = select && !m_ps;
      m_pm = move;
      m_ps = select;
      cur0 = m_cur;
      nm = n_matched();
      ncur = m_cur;
`ifdef MOVE_SKIP_MATCHED_EN
      if (mev && nm < 16) begin
         for (int k = 1; k < 16; k++) begin
            if (!m_mat[(m_cur + k) % 16]) begin ncur = (m_cur + k) % 16; break; end
         end
      end
`else
      if (mev) ncur = (m_cur + 1) % 16;
`endif
      if (m_hold > 0) begin
         if (m_hold == 1) begin m_rev[m_ha] = 0; m_rev[m_hb] = 0; end
         m_hold--;
      end else if (sev && nm < 16 && !m_rev[cur0] && !m_mat[cur0]) begin
         m_rev[cur0] = 1;
         if (m_first < 0) m_first = cur0;
         else begin
            if (m_cnt < 255) m_cnt++;
            if (face[m_first] == face[cur0]) begin
               m_mat[m_first] = 1; m_mat[cur0] = 1;
               m_rev[m_first] = 0; m_rev[cur0] = 0;
            end else begin
               m_hold = HOLD; m_ha = m_first; m_hb = cur0;
            end
            m_first = -1;
         end
      end
      m_cur = ncur;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         cycle++;
         #1;
         begin
            bit bad = 0;
            tests++;
            for (int i = 0; i < 16; i++) begin
               if (dut_c[i] !== 4'(expect_code(i))) begin
                  bad = 1;
                  if (fail_prints < 30) begin
                     fail_prints++;
                     $display("FAIL model_cell cycle %0d c%0d: got %h expected %h", cycle, i + 1, dut_c[i], expect_code(i));
                  end
               end
            end
            if (counter !== 8'(m_cnt)) begin
               bad = 1;
               if (fail_prints < 30) begin
                  fail_prints++;
                  $display("FAIL model_counter cycle %0d: got %0d expected %0d", cycle, counter, m_cnt);
               end
            end
            if (bad) fails++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_move();
      move = 1; @(negedge clk); move = 0; @(negedge clk);
   endtask

   task automatic sel_pulse();
      select = 1; @(negedge clk); select = 0; @(negedge clk);
   endtask

   task automatic goto(input int idx);
      for (int n = 0; n < 16 && m_cur != idx; n++) pulse_move();
   endtask

   task automatic do_reset();
      rst = 1; @(negedge clk); @(negedge clk); rst = 0; @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) face[i] = int'(deck[4*i +: 4]);
      rst = 1; move = 0; select = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("reset_c1", c1, 15); chk("reset_c2", c2, 0); chk("reset_c16", c16, 0);
      chk("reset_counter", counter, 0);

      pulse_move();
      chk("move_c1", c1, 0); chk("move_c2", c2, 15);

      move = 1; repeat (5) @(negedge clk); move = 0; @(negedge clk);
      chk("held_move_c3", c3, 15); chk("held_move_c2", c2, 0); chk("held_move_c4", c4, 0);

      goto(0);
      repeat (16) pulse_move();
      chk("wrap16_c1", c1, 15); chk("wrap16_c16", c16, 0);

      sel_pulse();
      chk("sel_c1", c1, 1); chk("sel_c1_counter", counter, 0);
      repeat (15) pulse_move();
      sel_pulse();
      chk("pair_c16", c16, 1); chk("pair_counter", counter, 1);
      pulse_move();
      sel_pulse();
      goto(15);
      sel_pulse();
      chk("matched_c1", c1, 1); chk("matched_c16", c16, 1); chk("matched_counter", counter, 1);

      goto(1);
      sel_pulse();
      chk("first_c2", c2, 2);
      pulse_move();
      select = 1; @(negedge clk); select = 0;
      chk("mis_c2", c2, 2); chk("mis_c3", c3, 3); chk("mis_counter", counter, 2);
      @(negedge clk);
      select = 1; @(negedge clk); select = 0; @(negedge clk);
      chk("hold_c2", c2, 2); chk("hold_counter", counter, 2);
      @(negedge clk);
      chk("hidden_c2", c2, 0); chk("hidden_c3", c3, 15); chk("hidden_counter", counter, 2);

      do_reset();
      for (int p = 0; p < 8; p++) begin
         goto(p); sel_pulse();
         goto(15 - p); sel_pulse();
      end
      chk("done_counter", counter, 8);
      for (int i = 0; i < 16; i++) chk($sformatf("done_c%0d", i + 1), dut_c[i], face[i]);
      sel_pulse(); pulse_move(); sel_pulse();
      chk("done_counter_stays", counter, 8); chk("done_c5", c5, 5);
      do_reset();
      chk("rerst_c1", c1, 15); chk("rerst_c5", c5, 0); chk("rerst_counter", counter, 0);

      // Drive repeated mismatches on adjacent cells to push the counter to saturation.
      for (int it = 0; it < 320; it++) begin
         if (face[m_cur] != face[(m_cur + 1) % 16]) begin
            select = 1; move = 1; @(negedge clk); select = 0; move = 0; @(negedge clk);
            sel_pulse();
            repeat (HOLD) @(negedge clk);
         end else begin
            pulse_move();
         end
      end
      chk("saturate_counter", counter, 255);

      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst    = ($urandom_range(0, 399) == 0);
         move   = ($urandom_range(0, 2) == 0);
         select = ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      rst = 0; move = 0; select = 0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
